// File: rtl/canvas_grid_capture.sv
// Canvas ink bitmap capture and row-major bit streamer.
// Optional feature macro: INK_COUNT_EN (adds ink_count output).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pix_valid/x/y/ink   cell-snapped pixel write (draw=1, erase=0)
//   clear               pulse, zero the live bitmap
//   start_scan          pulse, snapshot bitmap and start streaming
//   out_valid/ready     stream handshake, one cell per beat
//   out_bit/index/last  cell value, row*GRID_W+col, final-beat flag
//   busy                high while clearing or scanning
//   ink_count           set cells in live bitmap (INK_COUNT_EN only)
module canvas_grid_capture #(
  parameter logic [8:0] X0     = 9'd88,
  parameter logic [8:0] Y0     = 9'd37,
  parameter int         CELL_W = 10,
  parameter int         CELL_H = 14,
  parameter int         GRID_W = 14,
  parameter int         GRID_H = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic [8:0] pix_x,
  input  logic [8:0] pix_y,
  input  logic       pix_ink,
  input  logic       clear,
  input  logic       start_scan,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic [7:0] out_index,
  output logic       out_last,
`ifdef INK_COUNT_EN
  output logic [7:0] ink_count,
`endif
  output logic       busy
);

  localparam int N = GRID_W * GRID_H;

  localparam logic [8:0] CW9  = 9'(CELL_W);
  localparam logic [8:0] CH9  = 9'(CELL_H);
  localparam logic [8:0] GW9  = 9'(GRID_W);
  localparam logic [8:0] GH9  = 9'(GRID_H);
  localparam logic [7:0] LAST = 8'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SCAN  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [7:0]   idx_q, idx_d;
  logic [N-1:0] bitmap_q, bitmap_d;
  logic [N-1:0] snap_q, snap_d;

  // Pixel-to-cell decode
  logic [8:0] dx, dy;
  logic [8:0] col, row;
  logic       in_canvas;
  logic       wr_en;
  logic [7:0] wr_idx;

  always_comb begin
    dx = pix_x - X0;
    dy = pix_y - Y0;
    col = dx / CW9;
    row = dy / CH9;
    // The lower-bound checks also guard against
    // the subtractions wrapping around.
    in_canvas = (pix_x >= X0) && (pix_y >= Y0)
             && (col < GW9) && (row < GH9);
    // A clear in the same cycle wins over a write.
    wr_en = pix_valid && in_canvas && !clear;
    wr_idx = 8'(row * GW9 + col);
  end

  // Live bitmap next state
  always_comb begin
    bitmap_d = bitmap_q;
    if (clear) begin
      bitmap_d = '0;
    end else if (wr_en) begin
      bitmap_d[wr_idx] = pix_ink;
    end
  end

  wire scan_go = (state_q == S_IDLE)
              && start_scan && !clear;
  wire xfer    = (state_q == S_SCAN) && out_ready;

  // Control FSM and stream index
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (clear) begin
          state_d = S_CLEAR;
        end else if (start_scan) begin
          state_d = S_SCAN;
          idx_d   = '0;
          // Snapshot includes a same-cycle write.
          snap_d  = bitmap_d;
        end
      end
      (state_q == S_CLEAR): begin
        state_d = S_IDLE;
      end
      (state_q == S_SCAN): begin
        if (xfer) begin
          if (idx_q == LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      bitmap_q <= '0;
      snap_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bitmap_q <= bitmap_d;
      snap_q   <= snap_d;
    end
  end

  // Outputs are pure decodes of registered state,
  // so they hold steady across a stall.
  always_comb begin
    out_valid = (state_q == S_SCAN);
    out_bit   = out_valid && snap_q[idx_q];
    out_index = idx_q;
    out_last  = out_valid && (idx_q == LAST);
    busy      = (state_q != S_IDLE);
  end

`ifdef INK_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Count moves only on a real 0->1 or 1->0 change.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wr_en
             && (bitmap_q[wr_idx] != pix_ink)) begin
      if (pix_ink) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ink_count = cnt_q;
`endif

  // scan_go is kept as a named term for readability
  // of waveforms; it mirrors the IDLE->SCAN arc.
  logic scan_go_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_go_q <= 1'b0;
    end else begin
      scan_go_q <= scan_go;
    end
  end

  logic unused_ok;
  assign unused_ok = scan_go_q;

endmodule

// File: tb/tb_canvas_grid_capture.sv
// Self-checking bench for canvas_grid_capture.
// Reference model: plain cell array plus snapshot copy.
module tb_canvas_grid_capture;

  localparam int N = 196;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid;
  logic [8:0] pix_x;
  logic [8:0] pix_y;
  logic       pix_ink;
  logic       clear;
  logic       start_scan;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic [7:0] out_index;
  logic       out_last;
  logic       busy;
`ifdef INK_COUNT_EN
  logic [7:0] ink_count;
`endif

  int errors = 0;
  int checks = 0;

  bit model[N];

  always #5 clk = ~clk;

  canvas_grid_capture dut (
    .clk        (clk),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_ink    (pix_ink),
    .clear      (clear),
    .start_scan (start_scan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_index  (out_index),
    .out_last   (out_last),
`ifdef INK_COUNT_EN
    .ink_count  (ink_count),
`endif
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_wr(input int x, input int y,
                                   input bit ink);
    int c, r;
    if (x < 88 || y < 37) return;
    c = (x - 88) / 10;
    r = (y - 37) / 14;
    if (c >= 14 || r >= 14) return;
    model[r * 14 + c] = ink;
  endfunction

  function automatic int model_cnt();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(model[i]);
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) model[i] = 1'b0;
  endfunction

  task automatic wr(input int x, input int y, input bit ink);
    pix_x = 9'(x);
    pix_y = 9'(y);
    pix_ink = ink;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    model_wr(x, y, ink);
`ifdef INK_COUNT_EN
    checks++;
    if (ink_count !== 8'(model_cnt())) begin
      errors++;
      $display("FAIL ink_count after wr(%0d,%0d,%0b): got %0d want %0d",
               x, y, ink, ink_count, model_cnt());
    end
`endif
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy: got %b want 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle: got %b want 0", busy);
    end
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1, 2: random.
  // Optional write in the start cycle and one mid-scan.
  task automatic run_scan(input int mode,
                          input bit pre_wr, input int px,
                          input int py, input bit pink,
                          input bit mid_wr, input int mx,
                          input int my, input bit mink);
    bit snap[N];
    bit pat[4];
    int cnt = 0;
    int cyc = 0;
    bit hold = 0;
    logic hb, hl;
    logic [7:0] hi;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    start_scan = 1'b1;
    if (pre_wr) begin
      pix_x = 9'(px); pix_y = 9'(py);
      pix_ink = pink; pix_valid = 1'b1;
    end
    tick();
    start_scan = 1'b0;
    pix_valid = 1'b0;
    if (pre_wr) model_wr(px, py, pink);
    snap = model;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 8'd0) begin
      errors++;
      $display("FAIL scan_start: valid=%b idx=%0d want 1/0",
               out_valid, out_index);
    end
    while (cnt < N && cyc < 4000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = pat[cyc % 4];
        default: out_ready = 1'($urandom % 2);
      endcase
      start_scan = (cyc == 7);
      if (mid_wr && cyc == 20) begin
        pix_x = 9'(mx); pix_y = 9'(my);
        pix_ink = mink; pix_valid = 1'b1;
      end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL scan_bubble: valid=%b at beat %0d",
                 out_valid, cnt);
      end
      if (hold) begin
        checks++;
        if (out_bit !== hb || out_index !== hi
            || out_last !== hl) begin
          errors++;
          $display("FAIL stall_hold: got %b/%0d/%b want %b/%0d/%b",
                   out_bit, out_index, out_last, hb, hi, hl);
        end
      end
      hold = 0;
      if (out_ready) begin
        checks++;
        if (out_index !== 8'(cnt) || out_bit !== snap[cnt]
            || out_last !== (cnt == N - 1)) begin
          errors++;
          $display("FAIL beat %0d: got bit=%b idx=%0d last=%b want %b/%0d/%b",
                   cnt, out_bit, out_index, out_last,
                   snap[cnt], cnt, (cnt == N - 1));
        end
        cnt++;
      end else begin
        hold = 1;
        hb = out_bit; hi = out_index; hl = out_last;
      end
      tick();
      if (mid_wr && cyc == 20) begin
        pix_valid = 1'b0;
        model_wr(mx, my, mink);
      end
      cyc++;
    end
    start_scan = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (cnt != N) begin
      errors++;
      $display("FAIL scan_count: got %0d beats want %0d", cnt, N);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0
        || out_index !== 8'd0) begin
      errors++;
      $display("FAIL scan_end: valid=%b busy=%b idx=%0d want 0/0/0",
               out_valid, busy, out_index);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    checks++;
    if (out_valid !== 1'b0 || out_bit !== 1'b0
        || out_last !== 1'b0 || busy !== 1'b0
        || out_index !== 8'd0) begin
      errors++;
      $display("FAIL reset: v=%b b=%b l=%b busy=%b idx=%0d want zeros",
               out_valid, out_bit, out_last, busy, out_index);
    end
`ifdef INK_COUNT_EN
    checks++;
    if (ink_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", ink_count);
    end
`endif
  endtask

  task automatic test_empty_scan;
    run_scan(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_draw;
    wr(100, 51, 1);
    wr(231, 229, 1);
    wr(218, 219, 1);
    checks++;
    if (!model[15] || !model[195] || model_cnt() != 2) begin
      errors++;
      $display("FAIL draw_model: cells 15/195 not as required");
    end
    run_scan(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_out_of_canvas;
    pulse_clear();
    wr(87, 40, 1);
    wr(100, 36, 1);
    wr(300, 100, 1);
    run_scan(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall;
    wr(100, 51, 1);
    wr(88, 37, 1);
    wr(217, 218, 1);
    run_scan(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_snapshot;
    wr(100, 51, 1);
    run_scan(0, 0, 0, 0, 0, 1, 100, 51, 0);
    checks++;
    if (model[15] !== 1'b0) begin
      errors++;
      $display("FAIL snap_model: cell 15 got %b want 0", model[15]);
    end
    // Second scan also captures a same-cycle write.
    run_scan(0, 1, 150, 100, 1, 0, 0, 0, 0);
  endtask

  task automatic test_clear;
    wr(120, 80, 1);
    clear = 1'b1;
    pix_x = 9'd100; pix_y = 9'd51;
    pix_ink = 1'b1; pix_valid = 1'b1;
    tick();
    clear = 1'b0;
    pix_valid = 1'b0;
    model_clear();
    tick();
    wr(100, 51, 1);
    wr(110, 51, 1);
    wr(120, 90, 1);
    wr(110, 51, 1);
    wr(130, 60, 0);
    pulse_clear();
`ifdef INK_COUNT_EN
    checks++;
    if (ink_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_count: got %0d want 0", ink_count);
    end
`endif
    clear = 1'b1;
    start_scan = 1'b1;
    tick();
    clear = 1'b0;
    start_scan = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_scan: busy=%b valid=%b want 1/0",
               busy, out_valid);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_scan_idle: busy=%b valid=%b want 0/0",
               busy, out_valid);
    end
    run_scan(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_scan;
    wr(140, 70, 1);
    start_scan = 1'b1;
    out_ready = 1'b1;
    tick();
    start_scan = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    model_clear();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0
        || out_index !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_scan: v=%b busy=%b idx=%0d want 0/0/0",
               out_valid, busy, out_index);
    end
    run_scan(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random;
    pulse_clear();
    for (int i = 0; i < 120; i++) begin
      wr(int'($urandom_range(240, 70)),
         int'($urandom_range(250, 20)),
         1'($urandom % 2));
    end
    run_scan(2, 1, int'($urandom_range(217, 88)),
             int'($urandom_range(232, 37)), 1'b1,
             1, int'($urandom_range(217, 88)),
             int'($urandom_range(232, 37)), 1'b0);
    run_scan(2, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    pix_valid = 1'b0;
    pix_x = '0;
    pix_y = '0;
    pix_ink = 1'b0;
    clear = 1'b0;
    start_scan = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_empty_scan();
    test_draw();
    test_out_of_canvas();
    test_stall();
    test_snapshot();
    test_clear();
    test_reset_mid_scan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
